// File: rtl/sample_bram_ctrl_if.sv
// Bus bundle between the sample buffer controller, the UART word assembler,
// the FIR engine and a single-port BRAM.
interface sample_bram_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              i_clear;
    logic              i_wr_valid;
    logic [31:0]       i_wr_data;
    logic              o_wr_busy;
    logic              i_rd_req;
    logic              o_rd_busy;
    logic [31:0]       o_rd_data;
    logic              o_rd_valid;
    logic              o_bram_en;
    logic              o_bram_we;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [31:0]       o_bram_wdata;
    logic [31:0]       i_bram_rdata;
    logic [ADDR_W:0]   o_count;
    logic              o_full;

    modport slave (
        input  i_clear, i_wr_valid, i_wr_data, i_rd_req, i_bram_rdata,
        output o_wr_busy, o_rd_busy, o_rd_data, o_rd_valid,
               o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
               o_count, o_full
    );

    modport master (
        output i_clear, i_wr_valid, i_wr_data, i_rd_req, i_bram_rdata,
        input  o_wr_busy, o_rd_busy, o_rd_data, o_rd_valid,
               o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
               o_count, o_full
    );
endinterface

// File: rtl/sample_bram_ctrl.sv
// Sample buffer controller: arbitrates one pending write and one pending read
// onto a single-port BRAM; stored samples are replayed cyclically by reads.
module sample_bram_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sample_bram_ctrl_if.slave bus
);
    localparam int              DATA_W  = 32;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {EMPTY, FILL, FULL} phase_t;

    phase_t              state, state_nxt;
    logic                full;
    logic                wr_pend, rd_pend, rd_first;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count, count_inc, rd_ptr_inc;
    logic                wr_cap, rd_cap, conflict, grant_wr, grant_rd;
    logic                rd_vld_p1, rd_vld_p2;
    logic [DATA_W-1:0]   rd_data_p2;

    assign count_inc  = count + 1'b1;
    assign rd_ptr_inc = {1'b0, rd_ptr} + 1'b1;

    assign bus.o_wr_busy = wr_pend | full;
    assign bus.o_rd_busy = rd_pend | (count == '0);
    assign wr_cap        = bus.i_wr_valid & ~bus.o_wr_busy & ~bus.i_clear;
    assign rd_cap        = bus.i_rd_req & ~bus.o_rd_busy & ~bus.i_clear;
    assign conflict      = wr_pend & rd_pend;

    // On a conflict, rd_first remembers which side lost last time.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!bus.i_clear) begin
            if (conflict) begin
                grant_rd = rd_first;
                grant_wr = ~rd_first;
            end else begin
                grant_wr = wr_pend;
                grant_rd = rd_pend;
            end
        end
    end

    assign bus.o_bram_en    = grant_wr | grant_rd;
    assign bus.o_bram_we    = grant_wr;
    assign bus.o_bram_addr  = grant_wr ? wr_addr_q : (grant_rd ? rd_ptr : '0);
    assign bus.o_bram_wdata = grant_wr ? wr_data_q : '0;
    assign bus.o_count      = count;
    assign bus.o_full       = full;
    assign bus.o_rd_data    = rd_data_p2;
    assign bus.o_rd_valid   = rd_vld_p2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        full      = 1'b0;
        case (state)
            EMPTY:   if (grant_wr) state_nxt = (count_inc == DEPTH_C) ? FULL : FILL;
            FILL:    if (grant_wr && count_inc == DEPTH_C) state_nxt = FULL;
            FULL:    full = 1'b1;
            default: state_nxt = EMPTY;
        endcase
        if (bus.i_clear) state_nxt = EMPTY;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            rd_first <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.i_clear) begin
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            rd_first <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (grant_wr) begin
                wr_pend <= 1'b0;
                wr_ptr  <= wr_ptr + 1'b1;
                count   <= count_inc;
            end else if (wr_cap) begin
                wr_pend <= 1'b1;
            end
            if (grant_rd) begin
                rd_pend <= 1'b0;
                rd_ptr  <= (rd_ptr_inc == count) ? '0 : rd_ptr_inc[ADDR_W-1:0];
            end else if (rd_cap) begin
                rd_pend <= 1'b1;
            end
            if (conflict) rd_first <= grant_wr;
        end
    end

    // Write holding register is pure data; wr_pend qualifies it.
    always_ff @(posedge i_clk) begin
        if (wr_cap) begin
            wr_data_q <= bus.i_wr_data;
            wr_addr_q <= wr_ptr;
        end
    end

    // Read return pipeline: strobe -> BRAM latency -> output register.
    // Not touched by i_clear so an in-flight read still completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_vld_p1  <= 1'b0;
            rd_vld_p2  <= 1'b0;
            rd_data_p2 <= '0;
        end else begin
            rd_vld_p1 <= grant_rd;
            rd_vld_p2 <= rd_vld_p1;
            if (rd_vld_p1) rd_data_p2 <= bus.i_bram_rdata;
        end
    end
endmodule
